// File: rtl/general_demux.sv
// Valid/ready demultiplexer: routes one input word per cycle to one of NUM_OUTPUTS
// single-entry holding registers; out-of-range selects are dropped and counted.
module general_demux #(
    parameter int NUM_OUTPUTS = 5,
    parameter int WIDTH       = 4
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [WIDTH-1:0]               in_data,
    input  logic [$clog2(NUM_OUTPUTS)-1:0] in_sel,
    input  logic                           in_valid,
    output logic                           in_ready,
    output logic [NUM_OUTPUTS*WIDTH-1:0]   out_data,
    output logic [NUM_OUTPUTS-1:0]         out_valid,
    input  logic [NUM_OUTPUTS-1:0]         out_ready,
    output logic                           err_sel,
    output logic [7:0]                     err_cnt
);

    localparam int NUM_SELECTORS = $clog2(NUM_OUTPUTS);
    localparam logic [NUM_SELECTORS:0] SEL_LIMIT = (NUM_SELECTORS+1)'(NUM_OUTPUTS);

    logic [NUM_OUTPUTS-1:0] hit;
    logic [NUM_OUTPUTS-1:0] load;
    logic                   sel_legal;
    logic                   slot_free;
    logic                   in_xfer;

    // Extra top bit keeps the range check exact when NUM_OUTPUTS is a power of two.
    assign sel_legal = ({1'b0, in_sel} < SEL_LIMIT);

    always_comb begin
        hit = '0;
        for (int unsigned k = 0; k < NUM_OUTPUTS; k++) begin
            hit[k] = (in_sel == NUM_SELECTORS'(k));
        end
    end

    assign slot_free = |(hit & (~out_valid | out_ready));
    assign in_ready  = rst_n & (sel_legal ? slot_free : 1'b1);
    assign in_xfer   = in_valid & in_ready;
    assign load      = in_xfer ? hit : '0;

    // A load on a channel being drained overrides the clear, giving full throughput.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= '0;
            out_data  <= '0;
        end else begin
            for (int unsigned k = 0; k < NUM_OUTPUTS; k++) begin
                if (load[k]) begin
                    out_valid[k]                 <= 1'b1;
                    out_data[k*WIDTH +: WIDTH]   <= in_data;
                end else if (out_ready[k]) begin
                    out_valid[k]                 <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_sel <= 1'b0;
            err_cnt <= '0;
        end else begin
            err_sel <= in_xfer & ~sel_legal;
            if (in_xfer && !sel_legal && err_cnt != 8'hFF) begin
                err_cnt <= err_cnt + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_general_demux.sv
// Directed self-checking bench for general_demux at NUM_OUTPUTS=5, WIDTH=4.
module tb_general_demux;

    logic        clk;
    logic        rst_n;
    logic [3:0]  in_data;
    logic [2:0]  in_sel;
    logic        in_valid;
    logic        in_ready;
    logic [19:0] out_data;
    logic [4:0]  out_valid;
    logic [4:0]  out_ready;
    logic        err_sel;
    logic [7:0]  err_cnt;

    int checks;
    int errors;
    logic [19:0] exp_bus;

    general_demux #(.NUM_OUTPUTS(5), .WIDTH(4)) dut (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_sel(in_sel),
        .in_valid(in_valid), .in_ready(in_ready), .out_data(out_data),
        .out_valid(out_valid), .out_ready(out_ready), .err_sel(err_sel),
        .err_cnt(err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; in_sel = '0; in_data = '0; out_ready = '1;
        #2;
        checks++; if (out_valid !== 5'b0) begin errors++; $display("FAIL reset_valid got %b want %b", out_valid, 5'b0); end
        checks++; if (out_data !== 20'h0) begin errors++; $display("FAIL reset_data got %h want %h", out_data, 20'h0); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_ready got %b want 0", in_ready); end
        checks++; if (err_cnt !== 8'd0 || err_sel !== 1'b0) begin errors++; $display("FAIL reset_err got %b/%0d want 0/0", err_sel, err_cnt); end
        tick(); tick();
        #3 rst_n = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        out_ready = 5'b11111;
        in_valid = 1'b1; in_sel = 3'd3; in_data = 4'hA;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL basic_ready got %b want 1", in_ready); end
        tick();
        in_valid = 1'b0;
        checks++; if (out_valid !== 5'b01000) begin errors++; $display("FAIL basic_valid got %b want %b", out_valid, 5'b01000); end
        checks++; if (out_data !== 20'h0A000) begin errors++; $display("FAIL basic_data got %h want %h", out_data, 20'h0A000); end
        tick();
        checks++; if (out_valid !== 5'b00000) begin errors++; $display("FAIL basic_drain got %b want %b", out_valid, 5'b0); end
        checks++; if (out_data !== 20'h0A000) begin errors++; $display("FAIL basic_hold got %h want %h", out_data, 20'h0A000); end
    endtask

    task automatic test_backpressure();
        out_ready = 5'b11101;
        in_valid = 1'b1; in_sel = 3'd1; in_data = 4'h5;
        tick();
        in_data = 4'h6;
        #1;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_stall_ready got %b want 0", in_ready); end
        tick();
        checks++; if (out_valid !== 5'b00010) begin errors++; $display("FAIL bp_hold_valid got %b want %b", out_valid, 5'b00010); end
        checks++; if (out_data !== 20'h0A050) begin errors++; $display("FAIL bp_hold_data got %h want %h", out_data, 20'h0A050); end
        // channel 1 stalled; other channel must still accept
        in_sel = 3'd0; in_data = 4'h7;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL nb_ready got %b want 1", in_ready); end
        tick();
        in_valid = 1'b0;
        checks++; if (out_valid !== 5'b00011) begin errors++; $display("FAIL nb_valid got %b want %b", out_valid, 5'b00011); end
        checks++; if (out_data !== 20'h0A057) begin errors++; $display("FAIL nb_data got %h want %h", out_data, 20'h0A057); end
        tick();
        out_ready = 5'b11111;
        in_valid = 1'b1; in_sel = 3'd1; in_data = 4'h6;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_release_ready got %b want 1", in_ready); end
        tick();
        in_valid = 1'b0;
        checks++; if (out_valid !== 5'b00010) begin errors++; $display("FAIL bp_new_valid got %b want %b", out_valid, 5'b00010); end
        checks++; if (out_data !== 20'h0A067) begin errors++; $display("FAIL bp_new_data got %h want %h", out_data, 20'h0A067); end
        tick();
        checks++; if (out_valid !== 5'b00000) begin errors++; $display("FAIL bp_drain got %b want %b", out_valid, 5'b0); end
    endtask

    task automatic test_stream();
        int seen;
        int s;
        logic [3:0] d;
        seen = 0;
        exp_bus = 20'h0A067;
        out_ready = 5'b11111;
        for (int i = 0; i < 100; i++) begin
            s = int'($urandom_range(4, 0));
            d = 4'($urandom_range(15, 0));
            in_valid = 1'b1; in_sel = 3'(s); in_data = d;
            #1;
            checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL stream_ready[%0d] got %b want 1", i, in_ready); end
            exp_bus[s*4 +: 4] = d;
            tick();
            checks++; if (out_valid !== 5'(1 << s)) begin errors++; $display("FAIL stream_valid[%0d] got %b want %b", i, out_valid, 5'(1 << s)); end
            checks++; if (out_data !== exp_bus) begin errors++; $display("FAIL stream_data[%0d] got %h want %h", i, out_data, exp_bus); end
            seen += $countones(out_valid);
        end
        in_valid = 1'b0;
        tick();
        seen += $countones(out_valid);
        checks++; if (seen !== 100) begin errors++; $display("FAIL stream_count got %0d want 100", seen); end
        checks++; if (err_cnt !== 8'd0) begin errors++; $display("FAIL stream_errcnt got %0d want 0", err_cnt); end
    endtask

    task automatic test_illegal();
        logic [2:0] sels [3];
        sels[0] = 3'd6; sels[1] = 3'd6; sels[2] = 3'd7;
        out_ready = 5'b11011;
        in_valid = 1'b1; in_sel = 3'd2; in_data = 4'hC;
        tick();
        checks++; if (out_valid !== 5'b00100) begin errors++; $display("FAIL ill_setup got %b want %b", out_valid, 5'b00100); end
        for (int i = 0; i < 3; i++) begin
            in_sel = sels[i]; in_data = 4'hF;
            #1;
            checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL ill_ready[%0d] got %b want 1", i, in_ready); end
            tick();
            checks++; if (err_sel !== 1'b1) begin errors++; $display("FAIL ill_pulse[%0d] got %b want 1", i, err_sel); end
            checks++; if (err_cnt !== 8'(i + 1)) begin errors++; $display("FAIL ill_cnt[%0d] got %0d want %0d", i, err_cnt, i + 1); end
            checks++; if (out_valid !== 5'b00100) begin errors++; $display("FAIL ill_valid[%0d] got %b want %b", i, out_valid, 5'b00100); end
        end
        in_valid = 1'b0;
        tick();
        checks++; if (err_sel !== 1'b0) begin errors++; $display("FAIL ill_pulse_end got %b want 0", err_sel); end
        checks++; if (err_cnt !== 8'd3) begin errors++; $display("FAIL ill_cnt_hold got %0d want 3", err_cnt); end
        checks++; if (out_data[11:8] !== 4'hC) begin errors++; $display("FAIL ill_ch2_data got %h want %h", out_data[11:8], 4'hC); end
        in_valid = 1'b1; in_sel = 3'd5;
        for (int i = 0; i < 251; i++) tick();
        checks++; if (err_cnt !== 8'd254) begin errors++; $display("FAIL sat_254 got %0d want 254", err_cnt); end
        for (int i = 0; i < 46; i++) tick();
        in_valid = 1'b0;
        checks++; if (err_cnt !== 8'd255) begin errors++; $display("FAIL sat_255 got %0d want 255", err_cnt); end
        tick();
        checks++; if (out_valid !== 5'b00100) begin errors++; $display("FAIL sat_valid got %b want %b", out_valid, 5'b00100); end
    endtask

    task automatic test_reset_mid();
        out_ready = 5'b00000;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; in_sel = 3'(i); in_data = 4'(i + 1);
            tick();
        end
        in_valid = 1'b0;
        checks++; if (out_valid !== 5'b00111) begin errors++; $display("FAIL mid_setup got %b want %b", out_valid, 5'b00111); end
        #3 rst_n = 1'b0;
        #1;
        checks++; if (out_valid !== 5'b0 || out_data !== 20'h0) begin errors++; $display("FAIL mid_outputs got %b/%h want 0/0", out_valid, out_data); end
        checks++; if (err_sel !== 1'b0 || err_cnt !== 8'd0) begin errors++; $display("FAIL mid_err got %b/%0d want 0/0", err_sel, err_cnt); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL mid_ready got %b want 0", in_ready); end
        tick();
        out_ready = 5'b11111;
        in_valid = 1'b1; in_sel = 3'd4; in_data = 4'h9;
        #3 rst_n = 1'b1;
        #1;
        checks++; if (out_valid !== 5'b0) begin errors++; $display("FAIL mid_empty got %b want 0", out_valid); end
        tick();
        in_valid = 1'b0;
        checks++; if (out_valid !== 5'b10000 || out_data !== 20'h90000) begin errors++; $display("FAIL mid_first got %b/%h want %b/%h", out_valid, out_data, 5'b10000, 20'h90000); end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_basic();
        test_backpressure();
        test_stream();
        test_illegal();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/general_demux.md
GENERAL_DEMUX -- requirements
Module: general_demux

Interface
REQ-001 The module SHALL have parameter NUM_OUTPUTS, default 5, meaning the number of output channels (legal range 2..64).
REQ-002 The module SHALL have parameter WIDTH, default 4, meaning the data bits per channel (legal range 1 or more).
REQ-003 The module SHALL have localparam NUM_SELECTORS = $clog2(NUM_OUTPUTS), meaning the select width.
REQ-004 Port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-005 Port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 Port in_data, input, WIDTH bits: the word to route.
REQ-007 Port in_sel, input, NUM_SELECTORS bits: the destination channel index.
REQ-008 Port in_valid, input, 1 bit: in_data and in_sel are valid.
REQ-009 Port in_ready, output, 1 bit: the block accepts the word this cycle.
REQ-010 Port out_data, output, NUM_OUTPUTS*WIDTH bits: channel k occupies bits [k*WIDTH +: WIDTH].
REQ-011 Port out_valid, output, NUM_OUTPUTS bits: bit k means channel k holds a word.
REQ-012 Port out_ready, input, NUM_OUTPUTS bits: bit k means the channel k consumer takes the word.
REQ-013 Port err_sel, output, 1 bit: one-cycle pulse when an out-of-range select is dropped.
REQ-014 Port err_cnt, output, 8 bits: saturating count of dropped words.

Function
REQ-015 Handshakes: an input transfer SHALL occur on a rising clk edge with in_valid=1 and in_ready=1; an output transfer on channel k SHALL occur on a rising clk edge with out_valid[k]=1 and out_ready[k]=1.
REQ-016 Each channel SHALL have one holding register (data plus valid flag); there SHALL be no other storage.
REQ-017 Legal select (in_sel < NUM_OUTPUTS): in_ready SHALL be combinational and equal to (!out_valid[in_sel] || out_ready[in_sel]).
REQ-018 Illegal select (in_sel >= NUM_OUTPUTS): in_ready SHALL be 1.
REQ-019 in_ready SHALL NOT depend on in_valid.
REQ-020 Accepted legal word: in the next cycle, out_data channel in_sel SHALL equal in_data and out_valid[in_sel] SHALL be 1 (latency 1 cycle).
REQ-021 Simultaneous output and input transfer on the same channel: the new word SHALL replace the old one, out_valid SHALL stay 1, and sustained throughput SHALL be 1 word per cycle.
REQ-022 Output transfer with no new word for that channel: out_valid[k] SHALL clear next cycle, and out_data channel k SHALL hold its last value.
REQ-023 A valid channel that is not read SHALL hold its data and valid stable until out_ready[k]=1, regardless of traffic to other channels.
REQ-024 out_ready on non-valid channels SHALL have no effect.
REQ-025 A stall on one channel SHALL block input only while in_sel targets that channel; there SHALL be no head-of-line state beyond the present input.
REQ-026 Accepted illegal word: the word SHALL be dropped, no out_valid SHALL change because of it, err_sel SHALL be 1 for exactly the next cycle, and err_cnt SHALL increment, saturating at 255.
REQ-027 When NUM_OUTPUTS is a power of two, no select is illegal; err_sel SHALL stay 0 and err_cnt SHALL stay 0.
REQ-028 Input X or changes while in_valid=0 SHALL NOT alter state.

Reset
REQ-029 While rst_n=0 (asynchronous assert), out_valid, out_data, err_sel and err_cnt SHALL all be 0 immediately.
REQ-030 While rst_n=0, in_ready SHALL be 0.
REQ-031 Reset asserted mid-operation SHALL discard all held words without any output transfer.
REQ-032 After release, the first transfer SHALL be possible on the first rising edge with rst_n=1.

Verification (NUM_OUTPUTS=5, WIDTH=4)
REQ-033 Basic routing: send in_sel=3, in_data=4'hA with out_ready all 1 -> next cycle out_valid=5'b01000, out_data[15:12]=4'hA, other fields 0.
REQ-034 Back-pressure: send sel=1 data=4'h5 with out_ready[1]=0, then offer sel=1 data=4'h6 -> in_ready=0, channel 1 holds 4'h5; raise out_ready[1] -> 4'h5 consumed and 4'h6 accepted in the same edge; 4'h6 valid next cycle.
REQ-035 Non-blocking: channel 1 stalled full, send sel=0 data=4'h7 -> accepted, out_valid=5'b00011, channel 1 data unchanged.
REQ-036 Streaming: 100 random words, random sel 0..4, out_ready all 1 -> one word per cycle, each output matching a scoreboard, no loss or duplication.
REQ-037 Illegal select: send sel=6 twice, then sel=7 -> no out_valid change, err_sel pulses 3 times, err_cnt=3; after 300 illegal words, err_cnt=255.
REQ-038 Reset mid-operation: 3 channels valid, pull rst_n low between clock edges -> outputs 0 at once, in_ready=0; after release, all channels empty.
